trace_axis_packer: RTL and testbench
====================================

TRACE_AXIS_PACKER -- requirements
Module: trace_axis_packer

Interface
REQ-001 Parameter XLEN, default 64, width of program counter.
REQ-002 Parameter DATA_WIDTH, default XLEN+32, width of packed trace word {pc, instr}.
REQ-003 Parameter FIFO_DEPTH, default 16 (power of two), number of buffered trace words.
REQ-004 Clock clk; reset rst_n, synchronous, active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 instr  input  32  instruction of current trace item.
REQ-008 pc  input  XLEN  program counter of current trace item.
REQ-009 pc_valid  input  1  instr/pc pair is retiring this cycle.
REQ-010 trace_enable  input  1  external gate (trigger/range/wfi logic result); 0 blocks capture.
REQ-011 force_tlast  input  1  marks the word captured this cycle as last of packet.
REQ-012 tlast_interval  input  32  words per packet; 0 = no periodic tlast.
REQ-013 M_AXIS_tvalid  output  1  head word valid.
REQ-014 M_AXIS_tready  input  1  downstream ready.
REQ-015 M_AXIS_tdata  output  DATA_WIDTH  head word, {pc, instr}.
REQ-016 M_AXIS_tlast  output  1  head word ends a packet.
REQ-017 ctrl_we  input  1  control write strobe, raw level.
REQ-018 ctrl_we_pos_edge / ctrl_we_neg_edge  output  1 each  one-cycle edge pulses of ctrl_we.
REQ-019 overflow  output  1  sticky: a capture was lost to full FIFO.

Function
REQ-020 Filter: drop = (instr == 32'h0000_0000) | (instr == 32'h0000_0013, canonical NOP); combinational, no latency.
REQ-021 Capture (push) = pc_valid & trace_enable & ~drop, evaluated each rising edge.
REQ-022 Captured word = {pc, instr}, pc in upper XLEN bits, instr in bits 31:0.
REQ-023 Packet counter cnt (32 bit): on push, if force_tlast or (tlast_interval != 0 and cnt+1 >= tlast_interval) store tlast=1 with word and cnt<=0; else store tlast=0, cnt<=cnt+1; no push leaves cnt unchanged.
REQ-024 FIFO stores {tlast, word}; first-in first-out; word pushed at edge N appears at output after edge N (visible in cycle N+1) if FIFO was empty.
REQ-025 M_AXIS_tvalid = FIFO not empty; tdata/tlast = head entry; tdata=0, tlast=0 while tvalid=0.
REQ-026 Pop on tvalid & tready; head, tvalid, tdata, tlast stable while tvalid & ~tready.
REQ-027 Full FIFO: push accepted only if pop occurs same cycle; otherwise word discarded, cnt not advanced, overflow<=1.
REQ-028 Empty FIFO with simultaneous push and tready: word still takes one cycle (no bypass).
REQ-029 Edge detector: register ctrl_we_d; pos_edge = ctrl_we & ~ctrl_we_d; neg_edge = ~ctrl_we & ctrl_we_d; combinational outputs.
REQ-030 tlast_interval changed mid-packet: >= comparison ends packet at next push if cnt+1 already exceeds new value.

Reset
REQ-031 rst_n=0 at an edge: FIFO emptied, cnt=0, overflow=0, ctrl_we_d=0, pending push ignored.
REQ-032 Outputs during/after reset: tvalid=0, tdata=0, tlast=0, overflow=0; edge outputs follow REQ-029 with ctrl_we_d=0.
REQ-033 Reset mid-packet discards buffered words; no partial packet flushed.

Structure
REQ-034 Shared package holds NOP/zero instruction constants and default widths.
REQ-035 One sub-module sig_edge_detect (clk, sig, pos_edge, neg_edge); FIFO and counter inline.

Verification
REQ-036 interval=4, 8 consecutive pushes, tready=1 -> 8 beats, tlast on beats 4 and 8, tdata={pc,instr} in order.
REQ-037 instr=0x13 and 0x0 with pc_valid=1 -> no beat; instr=0x0001 -> beat emitted, with force_tlast=1 tlast=1 and cnt restarts.
REQ-038 tready=0, 17 pushes (depth 16) -> 16 beats retained, overflow=1, 17th lost; release tready -> 16 beats in order.
REQ-039 ctrl_we 0->1 held 3 cycles ->0 -> pos_edge one cycle on rise, neg_edge one cycle on fall.
REQ-040 rst_n=0 for one edge with 5 words buffered -> tvalid=0, tdata=0, overflow=0 next cycle; next interval count starts at 1.

Source files
------------

// File: rtl/trace_axis_packer_pkg.sv
// Shared constants for the trace packer: filtered instruction encodings and default widths.
package trace_axis_packer_pkg;

  localparam int unsigned XLEN_DEF       = 64;
  localparam int unsigned INSTR_W        = 32;
  localparam int unsigned FIFO_DEPTH_DEF = 16;
  localparam int unsigned CNT_W          = 32;

  // All-zero word and canonical NOP (addi x0, x0, 0) carry no trace information.
  localparam logic [INSTR_W-1:0] INSTR_ZERO = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] INSTR_NOP  = 32'h0000_0013;

  // True when an instruction must not be captured into the trace stream.
  function automatic logic instr_is_dropped(input logic [INSTR_W-1:0] instr);
    return (instr == INSTR_ZERO) || (instr == INSTR_NOP);
  endfunction

endpackage

// File: rtl/trace_axis_packer_sig_edge_detect.sv
// One-cycle rising/falling edge pulses of a level signal.
// Ports: clk, rst_n (sync, active-low), sig (level in),
//        pos_edge / neg_edge (combinational pulses against the registered previous level).
module sig_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic pos_edge,
  output logic neg_edge
);

  logic r_sig_d;

  // Previous-cycle level of sig.
  always_ff @(posedge clk) begin
    if (!rst_n) r_sig_d <= 1'b0;
    else        r_sig_d <= sig;
  end

  assign pos_edge = sig & ~r_sig_d;
  assign neg_edge = ~sig & r_sig_d;

endmodule

// File: rtl/trace_axis_packer.sv
// Filters retired instructions, packs {pc, instr} words into a FIFO and streams them
// out on an AXI-Stream master with periodic or forced tlast.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   instr, pc, pc_valid              retiring trace item
//   trace_enable                     external capture gate
//   force_tlast, tlast_interval      packet framing controls
//   M_AXIS_tvalid/tready/tdata/tlast AXI-Stream master
//   ctrl_we, ctrl_we_pos/neg_edge    control strobe and its edge pulses
//   overflow                         sticky lost-capture flag
module trace_axis_packer
  import trace_axis_packer_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned DATA_WIDTH = XLEN + INSTR_W,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INSTR_W-1:0]    instr,
  input  logic [XLEN-1:0]       pc,
  input  logic                  pc_valid,
  input  logic                  trace_enable,
  input  logic                  force_tlast,
  input  logic [CNT_W-1:0]      tlast_interval,
  output logic                  M_AXIS_tvalid,
  input  logic                  M_AXIS_tready,
  output logic [DATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                  M_AXIS_tlast,
  input  logic                  ctrl_we,
  output logic                  ctrl_we_pos_edge,
  output logic                  ctrl_we_neg_edge,
  output logic                  overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_overflow;

  logic                  w_push_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_tlast;
  logic [DATA_WIDTH:0]   w_head;

  // Capture qualification and FIFO handshake.
  assign w_push_req = pc_valid & trace_enable & ~instr_is_dropped(instr);
  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = ~w_empty & M_AXIS_tready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign w_push     = w_push_req & (~w_full | w_pop);

  // Packet framing: >= lets a lowered interval close the packet at the next push.
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_tlast    = force_tlast | ((tlast_interval != '0) && (w_cnt_inc >= tlast_interval));

  // Storage has no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_tlast, DATA_WIDTH'({pc, instr})};
  end

  // Pointers, occupancy, packet counter and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_cnt    <= w_tlast ? '0 : w_cnt_inc;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push) r_overflow <= 1'b1;
    end
  end

  // Head entry is masked to zero while the FIFO is empty.
  assign w_head        = w_empty ? '0 : r_mem[r_rd_ptr];
  assign M_AXIS_tvalid = ~w_empty;
  assign M_AXIS_tdata  = w_head[DATA_WIDTH-1:0];
  assign M_AXIS_tlast  = w_head[DATA_WIDTH];
  assign overflow      = r_overflow;

  sig_edge_detect u_ctrl_we_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig      (ctrl_we),
    .pos_edge (ctrl_we_pos_edge),
    .neg_edge (ctrl_we_neg_edge)
  );

endmodule

// File: tb/tb_trace_axis_packer.sv
// Directed self-checking bench for trace_axis_packer with default parameters.
module tb_trace_axis_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        pc_valid;
  logic        trace_enable;
  logic        force_tlast;
  logic [31:0] tlast_interval;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready;
  logic [95:0] M_AXIS_tdata;
  logic        M_AXIS_tlast;
  logic        ctrl_we;
  logic        ctrl_we_pos_edge;
  logic        ctrl_we_neg_edge;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [96:0] beats[$];
  logic [96:0] exp_q[$];
  int          base;

  always #5 clk = ~clk;

  trace_axis_packer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr            (instr),
    .pc               (pc),
    .pc_valid         (pc_valid),
    .trace_enable     (trace_enable),
    .force_tlast      (force_tlast),
    .tlast_interval   (tlast_interval),
    .M_AXIS_tvalid    (M_AXIS_tvalid),
    .M_AXIS_tready    (M_AXIS_tready),
    .M_AXIS_tdata     (M_AXIS_tdata),
    .M_AXIS_tlast     (M_AXIS_tlast),
    .ctrl_we          (ctrl_we),
    .ctrl_we_pos_edge (ctrl_we_pos_edge),
    .ctrl_we_neg_edge (ctrl_we_neg_edge),
    .overflow         (overflow)
  );

  // Record each handshake that will complete at the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && M_AXIS_tvalid && M_AXIS_tready)
      beats.push_back({M_AXIS_tlast, M_AXIS_tdata});
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [96:0] mk(input logic t, input logic [63:0] p, input logic [31:0] i);
    return {t, p, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] p, input logic [31:0] i, input logic f);
    pc          = p;
    instr       = i;
    force_tlast = f;
    pc_valid    = 1'b1;
    tick();
    pc_valid    = 1'b0;
    force_tlast = 1'b0;
  endtask

  task automatic check_beats(input string tag);
    check({tag, "_count"}, 128'(beats.size() - base), 128'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (base + k < beats.size())
        check($sformatf("%s_beat%0d", tag, k), 128'(beats[base + k]), 128'(exp_q[k]));
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    instr          = '0;
    pc             = '0;
    pc_valid       = 1'b0;
    trace_enable   = 1'b1;
    force_tlast    = 1'b0;
    tlast_interval = '0;
    M_AXIS_tready  = 1'b0;
    ctrl_we        = 1'b0;
    tick();
    tick();

    // Reset state.
    check("rst_tvalid", 128'(M_AXIS_tvalid), 128'(0));
    check("rst_tdata", 128'(M_AXIS_tdata), 128'(0));
    check("rst_tlast", 128'(M_AXIS_tlast), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    check("rst_pos_edge", 128'(ctrl_we_pos_edge), 128'(0));
    check("rst_neg_edge", 128'(ctrl_we_neg_edge), 128'(0));
    rst_n = 1'b1;
    tick();

    // Periodic tlast every 4 words.
    tlast_interval = 32'd4;
    M_AXIS_tready  = 1'b1;
    base = beats.size();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      push(64'h1000 + 64'(4 * i), 32'h00A0_0000 + 32'(i), 1'b0);
      exp_q.push_back(mk((i % 4) == 3, 64'h1000 + 64'(4 * i), 32'h00A0_0000 + 32'(i)));
    end
    repeat (3) tick();
    check_beats("interval4");

    // Filtered instructions produce nothing.
    base = beats.size();
    exp_q.delete();
    push(64'h2000, 32'h0000_0013, 1'b0);
    push(64'h2004, 32'h0000_0000, 1'b0);
    repeat (3) tick();
    check_beats("drop");

    // Drops/gating do not advance the count; forced tlast restarts it.
    base = beats.size();
    exp_q.delete();
    push(64'h2008, 32'h0000_0001, 1'b0);
    push(64'h200C, 32'h0000_0002, 1'b0);
    trace_enable = 1'b0;
    push(64'h2010, 32'h0000_0003, 1'b0);
    trace_enable = 1'b1;
    push(64'h2014, 32'h0000_0013, 1'b1);
    push(64'h2018, 32'h0000_0001, 1'b1);
    push(64'h201C, 32'h0000_0004, 1'b0);
    push(64'h2020, 32'h0000_0005, 1'b0);
    push(64'h2024, 32'h0000_0006, 1'b0);
    push(64'h2028, 32'h0000_0007, 1'b0);
    exp_q.push_back(mk(1'b0, 64'h2008, 32'h0000_0001));
    exp_q.push_back(mk(1'b0, 64'h200C, 32'h0000_0002));
    exp_q.push_back(mk(1'b1, 64'h2018, 32'h0000_0001));
    exp_q.push_back(mk(1'b0, 64'h201C, 32'h0000_0004));
    exp_q.push_back(mk(1'b0, 64'h2020, 32'h0000_0005));
    exp_q.push_back(mk(1'b0, 64'h2024, 32'h0000_0006));
    exp_q.push_back(mk(1'b1, 64'h2028, 32'h0000_0007));
    repeat (3) tick();
    check_beats("force");

    // Fill past depth with the sink stalled.
    M_AXIS_tready  = 1'b0;
    tlast_interval = 32'd0;
    base = beats.size();
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      push(64'h3000 + 64'(4 * i), 32'h00B0_0000 + 32'(i), 1'b0);
      if (i < 16) exp_q.push_back(mk(1'b0, 64'h3000 + 64'(4 * i), 32'h00B0_0000 + 32'(i)));
      if (i == 15) check("full_no_overflow", 128'(overflow), 128'(0));
    end
    check("overflow_set", 128'(overflow), 128'(1));
    check("stall_tvalid", 128'(M_AXIS_tvalid), 128'(1));
    check("stall_head", 128'(M_AXIS_tdata), 128'({64'h3000, 32'h00B0_0000}));
    M_AXIS_tready = 1'b1;
    repeat (20) tick();
    check_beats("overflow");
    check("drained_tvalid", 128'(M_AXIS_tvalid), 128'(0));
    check("drained_tdata", 128'(M_AXIS_tdata), 128'(0));
    check("drained_tlast", 128'(M_AXIS_tlast), 128'(0));

    // No bypass through an empty FIFO.
    pc       = 64'h3100;
    instr    = 32'h0000_0055;
    pc_valid = 1'b1;
    #1;
    check("nobypass_same_cycle", 128'(M_AXIS_tvalid), 128'(0));
    tick();
    pc_valid = 1'b0;
    check("nobypass_next_tvalid", 128'(M_AXIS_tvalid), 128'(1));
    check("nobypass_next_tdata", 128'(M_AXIS_tdata), 128'({64'h3100, 32'h0000_0055}));
    tick();
    check("nobypass_popped", 128'(M_AXIS_tvalid), 128'(0));
    check("overflow_sticky", 128'(overflow), 128'(1));

    // Reset with words buffered and a partial packet in flight.
    M_AXIS_tready  = 1'b0;
    tlast_interval = 32'd4;
    for (int i = 0; i < 5; i++) push(64'h4000 + 64'(4 * i), 32'h00C0_0000 + 32'(i), 1'b0);
    check("prereset_tvalid", 128'(M_AXIS_tvalid), 128'(1));
    rst_n = 1'b0;
    tick();
    check("midrst_tvalid", 128'(M_AXIS_tvalid), 128'(0));
    check("midrst_tdata", 128'(M_AXIS_tdata), 128'(0));
    check("midrst_overflow", 128'(overflow), 128'(0));
    rst_n = 1'b1;
    tick();
    check("postrst_tvalid", 128'(M_AXIS_tvalid), 128'(0));

    // Count restarts at 1; a lowered interval closes the packet at the next push.
    M_AXIS_tready  = 1'b1;
    tlast_interval = 32'd2;
    base = beats.size();
    exp_q.delete();
    push(64'h5000, 32'h0000_0001, 1'b0);
    push(64'h5004, 32'h0000_0002, 1'b0);
    tlast_interval = 32'd8;
    push(64'h5008, 32'h0000_0003, 1'b0);
    push(64'h500C, 32'h0000_0004, 1'b0);
    push(64'h5010, 32'h0000_0005, 1'b0);
    tlast_interval = 32'd2;
    push(64'h5014, 32'h0000_0006, 1'b0);
    exp_q.push_back(mk(1'b0, 64'h5000, 32'h0000_0001));
    exp_q.push_back(mk(1'b1, 64'h5004, 32'h0000_0002));
    exp_q.push_back(mk(1'b0, 64'h5008, 32'h0000_0003));
    exp_q.push_back(mk(1'b0, 64'h500C, 32'h0000_0004));
    exp_q.push_back(mk(1'b0, 64'h5010, 32'h0000_0005));
    exp_q.push_back(mk(1'b1, 64'h5014, 32'h0000_0006));
    repeat (3) tick();
    check_beats("postreset");

    // ctrl_we edge pulses.
    ctrl_we = 1'b1;
    #1;
    check("rise_pos", 128'(ctrl_we_pos_edge), 128'(1));
    check("rise_neg", 128'(ctrl_we_neg_edge), 128'(0));
    tick();
    check("hold1_pos", 128'(ctrl_we_pos_edge), 128'(0));
    check("hold1_neg", 128'(ctrl_we_neg_edge), 128'(0));
    tick();
    check("hold2_pos", 128'(ctrl_we_pos_edge), 128'(0));
    tick();
    ctrl_we = 1'b0;
    #1;
    check("fall_neg", 128'(ctrl_we_neg_edge), 128'(1));
    check("fall_pos", 128'(ctrl_we_pos_edge), 128'(0));
    tick();
    check("idle_neg", 128'(ctrl_we_neg_edge), 128'(0));
    check("idle_pos", 128'(ctrl_we_pos_edge), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
